// File: rtl/riscv_cpu_pkg.sv
// Shared CPU package: memory arbiter state/owner encodings and default sizes.
package riscv_cpu_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/riscv_arb_select.sv
// Owner selection for the memory arbiter: data first, with an optional fetch
// starvation limiter enabled by MEM_ARB_FAIR_EN.
module riscv_arb_select
  import riscv_cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_req_i,
  input  logic       data_req_i,
  input  logic       instr_gnt_i,
  input  logic       data_gnt_i,
  output arb_owner_e owner_o
);

`ifdef MEM_ARB_FAIR_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // Count data grants that left a waiting fetch behind; any fetch grant clears.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (instr_gnt_i) begin
      starve_cnt_d = '0;
    end else if (data_gnt_i && instr_req_i && (starve_cnt_q != LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    owner_o = OWNER_INSTR;
    if (data_req_i && !(instr_req_i && (starve_cnt_q == LIMIT))) begin
      owner_o = OWNER_DATA;
    end
  end
`else
  logic unused_fair;
  assign unused_fair = ^{clk, rst, instr_req_i, instr_gnt_i, data_gnt_i};
  assign owner_o     = data_req_i ? OWNER_DATA : OWNER_INSTR;
`endif

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares the single memory port between fetch and load/store, one outstanding
// transaction at a time. Define MEM_ARB_FAIR_EN to enable the fetch starvation limiter.
module riscv_mem_arbiter
  import riscv_cpu_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = riscv_cpu_pkg::DATA_WIDTH,
  parameter int STARVE_LIMIT   = STARVE_LIMIT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      instr_req_i,
  input  logic [MEM_ADDR_WIDTH-1:0] instr_addr_i,
  output logic                      instr_gnt_o,
  output logic                      instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]     instr_rdata_o,
  input  logic                      data_req_i,
  input  logic                      data_we_i,
  input  logic [DATA_WIDTH/8-1:0]   data_be_i,
  input  logic [MEM_ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0]     data_wdata_i,
  output logic                      data_gnt_o,
  output logic                      data_rvalid_o,
  output logic [DATA_WIDTH-1:0]     data_rdata_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d, sel_owner;
  logic       instr_gnt, data_gnt;

  assign instr_gnt = (state_q == ARB_REQ) && mem_gnt_i && (owner_q == OWNER_INSTR);
  assign data_gnt  = (state_q == ARB_REQ) && mem_gnt_i && (owner_q == OWNER_DATA);

  riscv_arb_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_select (
    .clk        (clk),
    .rst        (rst),
    .instr_req_i(instr_req_i),
    .data_req_i (data_req_i),
    .instr_gnt_i(instr_gnt),
    .data_gnt_i (data_gnt),
    .owner_o    (sel_owner)
  );

  // Owner is latched only when leaving IDLE and stays fixed until the response.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (instr_req_i || data_req_i) begin
          state_d = ARB_REQ;
          owner_d = sel_owner;
        end
      end
      ARB_REQ:  if (mem_gnt_i)    state_d = ARB_WAIT;
      ARB_WAIT: if (mem_rvalid_i) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= OWNER_INSTR;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Outputs are forced to zero for the whole reset cycle, not just after the edge.
  always_comb begin
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_be_o       = '0;
    mem_addr_o     = '0;
    mem_wdata_o    = '0;
    instr_gnt_o    = 1'b0;
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = '0;
    data_gnt_o     = 1'b0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = '0;
    if (!rst) begin
      instr_rdata_o = mem_rdata_i;
      data_rdata_o  = mem_rdata_i;
      instr_gnt_o   = instr_gnt;
      data_gnt_o    = data_gnt;
      if (state_q == ARB_REQ) begin
        mem_req_o = 1'b1;
        if (owner_q == OWNER_DATA) begin
          mem_we_o    = data_we_i;
          mem_be_o    = data_be_i;
          mem_addr_o  = data_addr_i;
          mem_wdata_o = data_wdata_i;
        end else begin
          mem_be_o   = '1;
          mem_addr_o = instr_addr_i;
        end
      end
      if ((state_q == ARB_WAIT) && mem_rvalid_i) begin
        instr_rvalid_o = (owner_q == OWNER_INSTR);
        data_rvalid_o  = (owner_q == OWNER_DATA);
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_riscv_mem_arbiter;

  localparam int LIM = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(
    .MEM_ADDR_WIDTH(32),
    .DATA_WIDTH    (32),
    .STARVE_LIMIT  (LIM)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_req_i   (instr_req_i),
    .instr_addr_i  (instr_addr_i),
    .instr_gnt_o   (instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o (instr_rdata_o),
    .data_req_i    (data_req_i),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_be_o      (mem_be_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  typedef struct packed {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        mgnt;
    logic        mrv;
    logic [31:0] mrdata;
  } in_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        igt;
    logic        irv;
    logic [31:0] irdata;
    logic        dgt;
    logic        drv;
    logic [31:0] drdata;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model: one outstanding transaction described by who owns it and
  // how far it has progressed (0 none, 1 awaiting grant, 2 awaiting response).
  int m_phase  = 0;
  int m_owner  = 0;
  int m_starve = 0;

  function automatic in_t I(input logic r, input logic ireq, input logic [31:0] iaddr,
                            input logic dreq, input logic dwe, input logic [3:0] dbe,
                            input logic [31:0] daddr, input logic [31:0] dwdata,
                            input logic mgnt, input logic mrv, input logic [31:0] mrdata);
    return '{r, ireq, iaddr, dreq, dwe, dbe, daddr, dwdata, mgnt, mrv, mrdata};
  endfunction

  function automatic out_t O(input logic req, input logic we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic igt, input logic irv, input logic [31:0] irdata,
                             input logic dgt, input logic drv, input logic [31:0] drdata);
    return '{req, we, be, addr, wdata, igt, irv, irdata, dgt, drv, drdata};
  endfunction

  function automatic out_t model_out(input in_t i);
    out_t o;
    o = '0;
    if (i.rst) return o;
    o.irdata = i.mrdata;
    o.drdata = i.mrdata;
    if (m_phase == 1) begin
      o.req = 1'b1;
      if (m_owner == 1) begin
        o.we = i.dwe; o.be = i.dbe; o.addr = i.daddr; o.wdata = i.dwdata;
        o.dgt = i.mgnt;
      end else begin
        o.be = 4'hF; o.addr = i.iaddr;
        o.igt = i.mgnt;
      end
    end
    if (m_phase == 2 && i.mrv) begin
      if (m_owner == 1) o.drv = 1'b1;
      else              o.irv = 1'b1;
    end
    return o;
  endfunction

  function automatic int pick_owner(input in_t i);
`ifdef MEM_ARB_FAIR_EN
    if (i.ireq && m_starve >= LIM) return 0;
`endif
    return i.dreq ? 1 : 0;
  endfunction

  task automatic model_advance(input in_t i);
    if (i.rst) begin
      m_phase = 0; m_owner = 0; m_starve = 0;
    end else if (m_phase == 0) begin
      if (i.ireq || i.dreq) begin
        m_owner = pick_owner(i);
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (i.mgnt) begin
        if (m_owner == 0)  m_starve = 0;
        else if (i.ireq)   m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
        m_phase = 2;
      end
    end else if (i.mrv) begin
      m_phase = 0;
    end
  endtask

  task automatic step(input in_t i, input out_t exp_o, input bit use_model, input string name);
    out_t act, e;
    assert (i.rst || !(m_phase == 1 && m_owner == 0 && !i.ireq))
      else $error("protocol: fetch owner withdrew request in %s", name);
    assert (i.rst || !(m_phase == 1 && m_owner == 1 && !i.dreq))
      else $error("protocol: data owner withdrew request in %s", name);
    rst = i.rst; instr_req_i = i.ireq; instr_addr_i = i.iaddr;
    data_req_i = i.dreq; data_we_i = i.dwe; data_be_i = i.dbe;
    data_addr_i = i.daddr; data_wdata_i = i.dwdata;
    mem_gnt_i = i.mgnt; mem_rvalid_i = i.mrv; mem_rdata_i = i.mrdata;
    #2;
    act = {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
           instr_gnt_o, instr_rvalid_o, instr_rdata_o,
           data_gnt_o, data_rvalid_o, data_rdata_o};
    e = use_model ? model_out(i) : exp_o;
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, e);
    end
    @(posedge clk);
    model_advance(i);
    #1;
  endtask

  out_t Z;
  vec_t tbl[$];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Z = '0;
    rst = 1'b1; instr_req_i = 0; instr_addr_i = 0; data_req_i = 0; data_we_i = 0;
    data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    @(posedge clk);
    #1;

    // Directed table: reset, single fetch, single store, stray response.
    tbl.push_back('{"rst_out", I(1,1,'h100,0,0,0,0,0,0,0,'h55), Z});
    tbl.push_back('{"f_idle",  I(0,1,'h100,0,0,0,0,0,0,0,0),    Z});
    tbl.push_back('{"f_gnt",   I(0,1,'h100,0,0,0,0,0,1,0,0),    O(1,0,4'hF,'h100,0,1,0,0,0,0,0)});
    tbl.push_back('{"f_rsp",   I(0,0,0,0,0,0,0,0,0,1,'h13),     O(0,0,0,0,0,0,1,'h13,0,0,'h13)});
    tbl.push_back('{"s_idle",  I(0,0,0,1,1,4'b0011,'h40,'hDEADBEEF,0,0,0), Z});
    tbl.push_back('{"s_gnt",   I(0,0,0,1,1,4'b0011,'h40,'hDEADBEEF,1,0,0),
                    O(1,1,4'b0011,'h40,'hDEADBEEF,0,0,0,1,0,0)});
    tbl.push_back('{"s_ack",   I(0,0,0,0,0,0,0,0,0,1,'h77),     O(0,0,0,0,0,0,0,'h77,0,1,'h77)});
    tbl.push_back('{"stray",   I(0,0,0,0,0,0,0,0,0,1,'h99),     O(0,0,0,0,0,0,0,'h99,0,0,'h99)});
    foreach (tbl[k]) step(tbl[k].i, tbl[k].o, 1'b0, tbl[k].name);

    // Simultaneous requests: data first, then fetch.
    step(I(0,1,'h200,1,0,4'hF,'h8000,0,0,0,0), Z, 0, "both_idle");
    step(I(0,1,'h200,1,0,4'hF,'h8000,0,1,0,0), O(1,0,4'hF,'h8000,0,0,0,0,1,0,0), 0, "both_dgnt");
    step(I(0,1,'h200,0,0,0,0,0,0,1,'hAA), O(0,0,0,0,0,0,0,'hAA,0,1,'hAA), 0, "both_drsp");
    step(I(0,1,'h200,0,0,0,0,0,0,0,0), Z, 0, "both_idle2");
    step(I(0,1,'h200,0,0,0,0,0,1,0,0), O(1,0,4'hF,'h200,0,1,0,0,0,0,0), 0, "both_igt");
    step(I(0,0,0,0,0,0,0,0,0,1,'h11), O(0,0,0,0,0,0,1,'h11,0,0,'h11), 0, "both_irsp");

    // Grant stall: owner and payload hold while fetch asserts.
    step(I(0,0,0,1,0,4'hF,'h300,0,0,0,0), Z, 0, "stall_idle");
    for (int k = 0; k < 5; k++)
      step(I(0,1,'h400,1,0,4'hF,'h300,0,0,0,0), O(1,0,4'hF,'h300,0,0,0,0,0,0,0), 0, "stall_hold");
    step(I(0,1,'h400,1,0,4'hF,'h300,0,1,0,0), O(1,0,4'hF,'h300,0,0,0,0,1,0,0), 0, "stall_gnt");
    step(I(0,1,'h400,0,0,0,0,0,0,1,'h5), O(0,0,0,0,0,0,0,'h5,0,1,'h5), 0, "stall_rsp");
    step(I(1,0,0,0,0,0,0,0,0,0,0), Z, 0, "rst2");

    // Both held continuously: grant order depends on the limiter.
    for (int n = 0; n < 6; n++) begin
      bit own_d;
`ifdef MEM_ARB_FAIR_EN
      own_d = (n % 3) != 2;
`else
      own_d = 1'b1;
`endif
      step(I(0,1,'h500,1,0,4'hF,'h600,0,0,0,0), Z, 0, "fair_idle");
      step(I(0,1,'h500,1,0,4'hF,'h600,0,1,0,0),
           own_d ? O(1,0,4'hF,'h600,0,0,0,0,1,0,0) : O(1,0,4'hF,'h500,0,1,0,0,0,0,0), 0, "fair_gnt");
      step(I(0,1,'h500,1,0,4'hF,'h600,0,0,1,'hC0),
           own_d ? O(0,0,0,0,0,0,0,'hC0,0,1,'hC0) : O(0,0,0,0,0,0,1,'hC0,0,0,'hC0), 0, "fair_rsp");
    end

    // Load the counter, then reset in WAIT: late response dropped, counter cleared.
    for (int n = 0; n < 2; n++) begin
      step(I(0,1,'h500,1,0,4'hF,'h600,0,0,0,0), Z, 0, "rw_pre_idle");
      step(I(0,1,'h500,1,0,4'hF,'h600,0,1,0,0), O(1,0,4'hF,'h600,0,0,0,0,1,0,0), 0, "rw_pre_gnt");
      step(I(0,1,'h500,0,0,0,0,0,0,1,'h1), O(0,0,0,0,0,0,0,'h1,0,1,'h1), 0, "rw_pre_rsp");
    end
    step(I(0,0,0,1,0,4'hF,'h700,0,0,0,0), Z, 0, "rw_idle");
    step(I(0,0,0,1,0,4'hF,'h700,0,1,0,0), O(1,0,4'hF,'h700,0,0,0,0,1,0,0), 0, "rw_gnt");
    step(I(1,0,0,0,0,0,0,0,0,0,'h3), Z, 0, "rw_rst");
    step(I(0,0,0,0,0,0,0,0,0,1,'hEE), O(0,0,0,0,0,0,0,'hEE,0,0,'hEE), 0, "rw_drop");
    step(I(0,1,'h500,1,0,4'hF,'h600,0,0,0,0), Z, 0, "rw_idle2");
    step(I(0,1,'h500,1,0,4'hF,'h600,0,1,0,0), O(1,0,4'hF,'h600,0,0,0,0,1,0,0), 0, "rw_cnt0");
    step(I(0,1,'h500,0,0,0,0,0,0,1,'h2), O(0,0,0,0,0,0,0,'h2,0,1,'h2), 0, "rw_rsp");

    // Randomized traffic: requesters hold until granted, memory timing is random.
    begin
      bit          ip, dp, dwe;
      logic [31:0] ia, da, dw;
      logic [3:0]  dbe;
      in_t         ri;
      out_t        eo;
      ip = 1'b1; ia = 32'h500; dp = 1'b0; da = 0; dw = 0; dwe = 0; dbe = 0;
      for (int c = 0; c < 800; c++) begin
        if (!ip && ($urandom % 3 == 0)) begin
          ip = 1'b1; ia = {$urandom} & 32'hFFFF_FFFC;
        end
        if (!dp && ($urandom % 3 == 0)) begin
          dp = 1'b1; da = $urandom; dw = $urandom; dwe = $urandom % 2; dbe = 4'($urandom);
        end
        ri = I(($urandom % 64) == 0, ip, ia, dp, dwe, dbe, da, dw,
               $urandom % 2, $urandom % 2, $urandom);
        eo = model_out(ri);
        step(ri, Z, 1'b1, "rand");
        if (ri.rst) begin
          ip = 1'b0; dp = 1'b0;
        end else begin
          if (eo.igt) ip = 1'b0;
          if (eo.dgt) dp = 1'b0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
